// File: rtl/bitscan_pkg.sv
// Shared constants and state encoding for the bit mask scanner.
// Order option: BITSCAN_MSB_FIRST_EN selects descending index emission.
package bitscan_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitscan_priority_enc.sv
// Combinational priority encoder over the remaining mask.
// BITSCAN_MSB_FIRST_EN picks the highest set bit instead of the lowest.
module bitscan_priority_enc
  import bitscan_pkg::*;
(
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             one_hot
);

  always_comb begin
    index = '0;
`ifdef BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (mask[i]) index = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (mask[i]) index = IDX_W'(i);
`endif
  end

  assign any     = |mask;
  // x & (x-1) drops the lowest set bit; zero result means at most one bit
  assign one_hot = any && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/bit_mask_scanner.sv
// Emits the index of every set bit of a latched mask over valid/ready.
// Order option: BITSCAN_MSB_FIRST_EN (descending), default ascending.
module bit_mask_scanner
  import bitscan_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_one;
  logic [WIDTH-1:0] sel;
  logic             in_scan;

  bitscan_priority_enc u_enc (
    .mask    (remaining),
    .index   (enc_idx),
    .any     (enc_any),
    .one_hot (enc_one)
  );

  assign sel     = WIDTH'(1) << enc_idx;
  assign in_scan = (state == SCAN);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = in_scan && enc_any;
  assign out_last  = in_scan && enc_one;
  assign out_index = in_scan ? enc_idx : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= data_operandA;
            count     <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (!enc_any) begin
            state <= DONE;
          end else if (out_ready) begin
            remaining <= remaining & ~sel;
            count     <= count + CNT_W'(1);
            if (enc_one) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
